// File: rtl/cpsr_flag_unit_pkg.sv
// cpsr_flag_unit_pkg: shared condition codes, FSM states and NZCV bit positions
package cpsr_flag_unit_pkg;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;
  typedef enum logic [1:0] {ST_IDLE, ST_HAZ, ST_EVAL, ST_RESP} state_t;
endpackage

// File: rtl/cpsr_flag_unit_if.sv
// cpsr_flag_unit_if: ALU flag-update, condition request and result channels
interface cpsr_flag_unit_if #(parameter int FLAG_W = 4, parameter int COND_W = 4, parameter int CNT_W = 8);
  logic flag_valid, flag_ready;
  logic [FLAG_W-1:0] flag_nzcv, flag_mask;
  logic cond_valid, cond_ready;
  logic [COND_W-1:0] cond_code;
  logic res_valid, res_ready, res_pass;
  logic [FLAG_W-1:0] cpsr_nzcv;
  logic [CNT_W-1:0] upd_count;
  modport master (
    output flag_valid, flag_nzcv, flag_mask, cond_valid, cond_code, res_ready,
    input flag_ready, cond_ready, res_valid, res_pass, cpsr_nzcv, upd_count
  );
  modport slave (
    input flag_valid, flag_nzcv, flag_mask, cond_valid, cond_code, res_ready,
    output flag_ready, cond_ready, res_valid, res_pass, cpsr_nzcv, upd_count
  );
endinterface

// File: rtl/cpsr_flag_unit_cond_eval.sv
// cpsr_flag_unit_cond_eval: combinational condition-code test against NZCV
module cpsr_flag_unit_cond_eval import cpsr_flag_unit_pkg::*; #(
  parameter int FLAG_W = 4,
  parameter int COND_W = 4
) (
  input  logic [COND_W-1:0] code,
  input  logic [FLAG_W-1:0] nzcv,
  output logic              pass
);
  logic n, z, c, v;
  logic [2**COND_W-1:0] truth;
  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];
  // one truth bit per condition, selected by the code
  always_comb begin
    truth = '0;
    truth[COND_EQ] = z;
    truth[COND_NE] = !z;
    truth[COND_CS] = c;
    truth[COND_CC] = !c;
    truth[COND_MI] = n;
    truth[COND_PL] = !n;
    truth[COND_VS] = v;
    truth[COND_VC] = !v;
    truth[COND_HI] = c & !z;
    truth[COND_LS] = !c | z;
    truth[COND_GE] = n == v;
    truth[COND_LT] = n != v;
    truth[COND_GT] = !z & (n == v);
    truth[COND_LE] = z | (n != v);
    truth[COND_AL] = 1'b1;
    truth[COND_NV] = 1'b0;
  end
  assign pass = truth[code];
endmodule

// File: rtl/cpsr_flag_unit.sv
// cpsr_flag_unit: CPSR NZCV register with condition evaluation handshake
// FLAG_FORWARD_EN: skip the hazard bubble when a flag write lands with a request
module cpsr_flag_unit import cpsr_flag_unit_pkg::*; #(
  parameter int FLAG_W = 4,
  parameter int COND_W = 4,
  parameter int CNT_W  = 8
) (
  input logic clk,
  input logic rst,
  cpsr_flag_unit_if.slave bus
);
  state_t state;
  logic [COND_W-1:0] code;
  logic [FLAG_W-1:0] cpsr;
  logic [CNT_W-1:0] cnt;
  logic fire, pass, frdy, crdy, rvalid, rpass;
  assign fire = bus.flag_valid & frdy;
  cpsr_flag_unit_cond_eval #(.FLAG_W(FLAG_W), .COND_W(COND_W)) u_eval (
    .code(code),
    .nzcv(cpsr),
    .pass(pass)
  );
  // request sequencing; flags are frozen only while evaluating
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      code <= '0;
      crdy <= 1'b1;
      frdy <= 1'b1;
      rvalid <= 1'b0;
      rpass <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.cond_valid) begin
          code <= bus.cond_code;
          crdy <= 1'b0;
`ifdef FLAG_FORWARD_EN
          state <= ST_EVAL;
          frdy <= 1'b0;
`else
          state <= fire ? ST_HAZ : ST_EVAL;
          frdy <= fire;
`endif
        end
        ST_HAZ: begin
          state <= ST_EVAL;
          frdy <= 1'b0;
        end
        ST_EVAL: begin
          state <= ST_RESP;
          rvalid <= 1'b1;
          rpass <= pass;
          frdy <= 1'b1;
        end
        ST_RESP: if (bus.res_ready) begin
          state <= ST_IDLE;
          rvalid <= 1'b0;
          crdy <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  // masked flag merge and saturating update counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cpsr <= '0;
      cnt <= '0;
    end else if (fire) begin
      cpsr <= (cpsr & ~bus.flag_mask) | (bus.flag_nzcv & bus.flag_mask);
      cnt <= cnt + {{(CNT_W-1){1'b0}}, ~&cnt};
    end
  assign bus.flag_ready = frdy;
  assign bus.cond_ready = crdy;
  assign bus.res_valid = rvalid;
  assign bus.res_pass = rpass;
  assign bus.cpsr_nzcv = cpsr;
  assign bus.upd_count = cnt;
endmodule
